// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus for the load/store unit.
//   req_*   : core -> unit access request (valid/ready handshake)
//   resp_*  : unit -> core completion pulse, load data and exception flag
//   mem_*   : unit <-> word-addressed data memory (asynchronous read)
// Modport slave is the unit side; master is the core/memory side.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_exc;
   logic [31:0] mem_address;
   logic        mem_write;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   modport slave (
      input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready,
      output resp_valid, resp_rdata, resp_exc,
      output mem_address, mem_write, mem_write_data,
      input  mem_read_data
   );

   modport master (
      output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready,
      input  resp_valid, resp_rdata, resp_exc,
      input  mem_address, mem_write, mem_write_data,
      output mem_read_data
   );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit between the core's load/store control and a word-only data memory.
// Adds sign/zero-extended byte and halfword loads, byte/halfword stores via a
// read-modify-write, and blocks misaligned or illegal-size accesses.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : load_store_unit_if.slave (request, response and memory signals)
// Parameter BIG_ENDIAN selects byte-lane order within a word.
module load_store_unit #(
   parameter bit BIG_ENDIAN = 1'b0
) (
   input logic              clk,
   input logic              rst,
   load_store_unit_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StRmw, StResp} state_e;

   state_e      state_q;
   // Only the fields still needed after the accept cycle are latched.
   logic [31:0] addr_q;
   logic [1:0]  size_q;
   logic [15:0] wdata_q;
   logic [31:0] merge_q;
   logic [31:0] rdata_q;
   logic        valid_q;
   logic        exc_q;

   logic        accept;
   logic        illegal;
   logic        sub_store;
   logic [1:0]  byte_lane;
   logic        half_lane;
   logic [1:0]  byte_lane_q;
   logic        half_lane_q;
   logic [7:0]  load_byte;
   logic [15:0] load_half;
   logic [31:0] load_ext;
   logic [31:0] merged;

   assign accept    = bus.req_valid & bus.req_ready;
   assign illegal   = (bus.req_size == 2'b11) ||
                      (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                      (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
   assign sub_store = bus.req_write & ~bus.req_size[1];

   // Big-endian puts the lowest-addressed byte/half in the most significant lane.
   assign byte_lane   = BIG_ENDIAN ? ~bus.req_addr[1:0] : bus.req_addr[1:0];
   assign half_lane   = BIG_ENDIAN ? ~bus.req_addr[1]   : bus.req_addr[1];
   assign byte_lane_q = BIG_ENDIAN ? ~addr_q[1:0]       : addr_q[1:0];
   assign half_lane_q = BIG_ENDIAN ? ~addr_q[1]         : addr_q[1];

   always_comb begin
      load_byte = bus.mem_read_data[{byte_lane, 3'b000} +: 8];
      load_half = bus.mem_read_data[{half_lane, 4'b0000} +: 16];
      case (bus.req_size)
         2'b00:   load_ext = bus.req_unsigned ? {24'h0, load_byte}
                                              : {{24{load_byte[7]}}, load_byte};
         2'b01:   load_ext = bus.req_unsigned ? {16'h0, load_half}
                                              : {{16{load_half[15]}}, load_half};
         default: load_ext = bus.mem_read_data;
      endcase
   end

   always_comb begin
      merged = merge_q;
      if (size_q == 2'b00) begin
         merged[{byte_lane_q, 3'b000} +: 8] = wdata_q[7:0];
      end else begin
         merged[{half_lane_q, 4'b0000} +: 16] = wdata_q;
      end
   end

   always_comb begin
      bus.req_ready      = (state_q == StIdle) & ~rst;
      bus.mem_address    = (state_q == StIdle) ? {bus.req_addr[31:2], 2'b00}
                                               : {addr_q[31:2], 2'b00};
      bus.mem_write_data = (state_q == StRmw) ? merged : bus.req_wdata;
      bus.mem_write      = 1'b0;
      if (!rst) begin
         if (state_q == StRmw) begin
            bus.mem_write = 1'b1;
         end else if (accept && bus.req_write && !illegal && bus.req_size == 2'b10) begin
            bus.mem_write = 1'b1;
         end
      end
      // Gating by rst drops a pending response pulse when reset lands in RESP.
      bus.resp_valid = valid_q & ~rst;
      bus.resp_exc   = exc_q;
      bus.resp_rdata = rdata_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         addr_q  <= 32'h0;
         size_q  <= 2'b00;
         wdata_q <= 16'h0;
         merge_q <= 32'h0;
         rdata_q <= 32'h0;
         valid_q <= 1'b0;
         exc_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (accept) begin
                  addr_q  <= bus.req_addr;
                  size_q  <= bus.req_size;
                  wdata_q <= bus.req_wdata[15:0];
                  if (illegal) begin
                     exc_q   <= 1'b1;
                     valid_q <= 1'b1;
                     state_q <= StResp;
                  end else if (sub_store) begin
                     merge_q <= bus.mem_read_data;
                     exc_q   <= 1'b0;
                     state_q <= StRmw;
                  end else begin
                     if (!bus.req_write) begin
                        rdata_q <= load_ext;
                     end
                     exc_q   <= 1'b0;
                     valid_q <= 1'b1;
                     state_q <= StResp;
                  end
               end
            end
            StRmw: begin
               valid_q <= 1'b1;
               state_q <= StResp;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   load_store_unit_if if_le ();
   load_store_unit_if if_be ();

   load_store_unit #(.BIG_ENDIAN(1'b0)) dut_le (.clk(clk), .rst(rst), .bus(if_le));
   load_store_unit #(.BIG_ENDIAN(1'b1)) dut_be (.clk(clk), .rst(rst), .bus(if_be));

   logic [31:0] mem_le [0:1023];
   logic [31:0] mem_be [0:1023];
   logic        pl_le_we;
   logic        pl_be_we;
   logic [9:0]  pl_idx;
   logic [31:0] pl_data;

   assign if_le.mem_read_data = mem_le[if_le.mem_address[11:2]];
   assign if_be.mem_read_data = mem_be[if_be.mem_address[11:2]];

   always @(posedge clk) begin
      if (pl_le_we) mem_le[pl_idx] <= pl_data;
      else if (if_le.mem_write) mem_le[if_le.mem_address[11:2]] <= if_le.mem_write_data;
   end

   always @(posedge clk) begin
      if (pl_be_we) mem_be[pl_idx] <= pl_data;
      else if (if_be.mem_write) mem_be[if_be.mem_address[11:2]] <= if_be.mem_write_data;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic preload(input bit be, input logic [31:0] byte_addr, input logic [31:0] data);
      pl_idx  = byte_addr[11:2];
      pl_data = data;
      if (be) pl_be_we = 1'b1;
      else pl_le_we = 1'b1;
      @(posedge clk);
      #1;
      pl_le_we = 1'b0;
      pl_be_we = 1'b0;
   endtask

   // Drives one access on the little-endian unit and records what happened.
   task automatic run_access(input logic w, input logic [1:0] sz, input logic u,
                             input logic [31:0] a, input logic [31:0] d,
                             output int lat, output logic acc_wr, output logic wr_seen,
                             output logic [31:0] wr_data, output logic exc,
                             output logic [31:0] rdata);
      int guard;
      if_le.req_write    = w;
      if_le.req_size     = sz;
      if_le.req_unsigned = u;
      if_le.req_addr     = a;
      if_le.req_wdata    = d;
      if_le.req_valid    = 1'b1;
      guard = 0;
      @(negedge clk);
      while (!if_le.req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      acc_wr  = if_le.mem_write;
      wr_seen = if_le.mem_write;
      wr_data = if_le.mem_write ? if_le.mem_write_data : 32'h0;
      @(posedge clk);
      #1;
      if_le.req_valid = 1'b0;
      lat = 0;
      exc = 1'b0;
      rdata = 32'h0;
      while (lat < 10) begin
         @(negedge clk);
         lat++;
         if (if_le.mem_write) begin
            wr_seen = 1'b1;
            wr_data = if_le.mem_write_data;
         end
         if (if_le.resp_valid) break;
      end
      if (!if_le.resp_valid) lat = 99;
      exc   = if_le.resp_exc;
      rdata = if_le.resp_rdata;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (if_le.req_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_ready_low: got %b expected 0", if_le.req_ready);
      end
      checks++;
      if (if_le.mem_write !== 1'b0) begin
         failures++;
         $display("FAIL reset_mem_write: got %b expected 0", if_le.mem_write);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (if_le.req_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready_after: got %b expected 1", if_le.req_ready);
      end
      checks++;
      if (if_le.resp_valid !== 1'b0 || if_le.resp_exc !== 1'b0) begin
         failures++;
         $display("FAIL reset_resp: got valid=%b exc=%b expected 0 0",
                  if_le.resp_valid, if_le.resp_exc);
      end
      checks++;
      if (if_le.resp_rdata !== 32'h0) begin
         failures++;
         $display("FAIL reset_rdata: got %h expected 00000000", if_le.resp_rdata);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_loads();
      logic [31:0] addr_t [3];
      logic        uns_t  [3];
      logic [1:0]  size_t [3];
      logic [31:0] exp_t  [3];
      int lat;
      logic acc_wr, wr_seen, exc;
      logic [31:0] wr_data, rdata;
      addr_t[0] = 32'h13; uns_t[0] = 1'b0; size_t[0] = 2'b00; exp_t[0] = 32'hFFFFFF88;
      addr_t[1] = 32'h13; uns_t[1] = 1'b1; size_t[1] = 2'b00; exp_t[1] = 32'h00000088;
      addr_t[2] = 32'h12; uns_t[2] = 1'b0; size_t[2] = 2'b01; exp_t[2] = 32'hFFFF8899;
      preload(1'b0, 32'h10, 32'h8899AABB);
      for (int i = 0; i < 3; i++) begin
         run_access(1'b0, size_t[i], uns_t[i], addr_t[i], 32'h0,
                    lat, acc_wr, wr_seen, wr_data, exc, rdata);
         checks++;
         if (rdata !== exp_t[i] || lat != 1 || exc !== 1'b0 || wr_seen !== 1'b0) begin
            failures++;
            $display("FAIL load_%0d: got rdata=%h lat=%0d exc=%b wr=%b expected %h 1 0 0",
                     i, rdata, lat, exc, wr_seen, exp_t[i]);
         end
      end
   endtask

   task automatic test_sub_store();
      int lat;
      logic acc_wr, wr_seen, exc;
      logic [31:0] wr_data, rdata;
      preload(1'b0, 32'h10, 32'h11223344);
      run_access(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000CC,
                 lat, acc_wr, wr_seen, wr_data, exc, rdata);
      checks++;
      if (acc_wr !== 1'b0) begin
         failures++;
         $display("FAIL sb_accept_write: got %b expected 0", acc_wr);
      end
      checks++;
      if (wr_seen !== 1'b1 || wr_data !== 32'h1122CC44) begin
         failures++;
         $display("FAIL sb_rmw_data: got wr=%b data=%h expected 1 1122cc44", wr_seen, wr_data);
      end
      checks++;
      if (lat != 2 || exc !== 1'b0) begin
         failures++;
         $display("FAIL sb_latency: got lat=%0d exc=%b expected 2 0", lat, exc);
      end
      run_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, acc_wr, wr_seen, wr_data, exc, rdata);
      checks++;
      if (rdata !== 32'h1122CC44 || lat != 1) begin
         failures++;
         $display("FAIL sb_readback: got %h lat=%0d expected 1122cc44 1", rdata, lat);
      end
      preload(1'b0, 32'h20, 32'hFFFFFFFF);
      run_access(1'b1, 2'b01, 1'b0, 32'h20, 32'hDEADBEEF,
                 lat, acc_wr, wr_seen, wr_data, exc, rdata);
      checks++;
      if (acc_wr !== 1'b0 || wr_data !== 32'hFFFFBEEF || lat != 2) begin
         failures++;
         $display("FAIL sh_rmw: got accwr=%b data=%h lat=%0d expected 0 ffffbeef 2",
                  acc_wr, wr_data, lat);
      end
      run_access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, acc_wr, wr_seen, wr_data, exc, rdata);
      checks++;
      if (rdata !== 32'hFFFFBEEF) begin
         failures++;
         $display("FAIL sh_readback: got %h expected ffffbeef", rdata);
      end
   endtask

   task automatic test_misaligned();
      logic        w_t  [3];
      logic [1:0]  sz_t [3];
      logic [31:0] a_t  [3];
      int lat;
      logic acc_wr, wr_seen, exc;
      logic [31:0] wr_data, rdata;
      w_t[0] = 1'b0; sz_t[0] = 2'b10; a_t[0] = 32'h22;
      w_t[1] = 1'b1; sz_t[1] = 2'b01; a_t[1] = 32'h21;
      w_t[2] = 1'b1; sz_t[2] = 2'b11; a_t[2] = 32'h24;
      for (int i = 0; i < 3; i++) begin
         run_access(w_t[i], sz_t[i], 1'b0, a_t[i], 32'h12345678,
                    lat, acc_wr, wr_seen, wr_data, exc, rdata);
         checks++;
         if (wr_seen !== 1'b0 || lat != 1 || exc !== 1'b1) begin
            failures++;
            $display("FAIL misaligned_%0d: got wr=%b lat=%0d exc=%b expected 0 1 1",
                     i, wr_seen, lat, exc);
         end
         // Last successful load returned 0xFFFFBEEF.
         checks++;
         if (rdata !== 32'hFFFFBEEF) begin
            failures++;
            $display("FAIL misaligned_rdata_%0d: got %h expected ffffbeef", i, rdata);
         end
      end
   endtask

   task automatic test_reset_in_rmw();
      logic seen_valid;
      preload(1'b0, 32'h30, 32'h55667788);
      if_le.req_write    = 1'b1;
      if_le.req_size     = 2'b00;
      if_le.req_unsigned = 1'b0;
      if_le.req_addr     = 32'h30;
      if_le.req_wdata    = 32'h000000AA;
      if_le.req_valid    = 1'b1;
      @(negedge clk);
      checks++;
      if (if_le.req_ready !== 1'b1) begin
         failures++;
         $display("FAIL rmwrst_ready: got %b expected 1", if_le.req_ready);
      end
      @(posedge clk);
      #1;
      if_le.req_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (if_le.mem_write !== 1'b0 || if_le.resp_valid !== 1'b0) begin
         failures++;
         $display("FAIL rmwrst_write: got wr=%b valid=%b expected 0 0",
                  if_le.mem_write, if_le.resp_valid);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      seen_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (if_le.req_ready !== 1'b1) begin
         failures++;
         $display("FAIL rmwrst_ready_after: got %b expected 1", if_le.req_ready);
      end
      repeat (3) begin
         if (if_le.resp_valid === 1'b1) seen_valid = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (seen_valid !== 1'b0) begin
         failures++;
         $display("FAIL rmwrst_no_resp: got resp_valid seen=%b expected 0", seen_valid);
      end
      checks++;
      if (mem_le[12] !== 32'h55667788) begin
         failures++;
         $display("FAIL rmwrst_mem: got %h expected 55667788", mem_le[12]);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      if_le.req_write    = 1'b1;
      if_le.req_size     = 2'b10;
      if_le.req_unsigned = 1'b0;
      if_le.req_addr     = 32'h40;
      if_le.req_wdata    = 32'h13579BDF;
      if_le.req_valid    = 1'b1;
      @(negedge clk);
      checks++;
      if (if_le.req_ready !== 1'b1 || if_le.mem_write !== 1'b1 ||
          if_le.mem_write_data !== 32'h13579BDF) begin
         failures++;
         $display("FAIL b2b_sw: got rdy=%b wr=%b data=%h expected 1 1 13579bdf",
                  if_le.req_ready, if_le.mem_write, if_le.mem_write_data);
      end
      @(posedge clk);
      #1;
      if_le.req_write = 1'b0;
      @(negedge clk);
      checks++;
      if (if_le.req_ready !== 1'b0 || if_le.resp_valid !== 1'b1 || if_le.mem_write !== 1'b0) begin
         failures++;
         $display("FAIL b2b_hold: got rdy=%b valid=%b wr=%b expected 0 1 0",
                  if_le.req_ready, if_le.resp_valid, if_le.mem_write);
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (if_le.req_ready !== 1'b1 || if_le.resp_valid !== 1'b0) begin
         failures++;
         $display("FAIL b2b_second_ready: got rdy=%b valid=%b expected 1 0",
                  if_le.req_ready, if_le.resp_valid);
      end
      @(posedge clk);
      #1;
      if_le.req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (if_le.resp_valid !== 1'b1 || if_le.resp_rdata !== 32'h13579BDF) begin
         failures++;
         $display("FAIL b2b_lw: got valid=%b rdata=%h expected 1 13579bdf",
                  if_le.resp_valid, if_le.resp_rdata);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_big_endian();
      logic [31:0] a_t   [2];
      logic        u_t   [2];
      logic [31:0] exp_t [2];
      a_t[0] = 32'h40; u_t[0] = 1'b0; exp_t[0] = 32'hFFFFFFA1;
      a_t[1] = 32'h43; u_t[1] = 1'b1; exp_t[1] = 32'h000000D4;
      preload(1'b1, 32'h40, 32'hA1B2C3D4);
      for (int i = 0; i < 2; i++) begin
         if_be.req_write    = 1'b0;
         if_be.req_size     = 2'b00;
         if_be.req_unsigned = u_t[i];
         if_be.req_addr     = a_t[i];
         if_be.req_wdata    = 32'h0;
         if_be.req_valid    = 1'b1;
         @(negedge clk);
         checks++;
         if (if_be.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL be_ready_%0d: got %b expected 1", i, if_be.req_ready);
         end
         @(posedge clk);
         #1;
         if_be.req_valid = 1'b0;
         @(negedge clk);
         checks++;
         if (if_be.resp_valid !== 1'b1 || if_be.resp_rdata !== exp_t[i]) begin
            failures++;
            $display("FAIL be_lb_%0d: got valid=%b rdata=%h expected 1 %h",
                     i, if_be.resp_valid, if_be.resp_rdata, exp_t[i]);
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      pl_le_we = 1'b0;
      pl_be_we = 1'b0;
      pl_idx   = 10'h0;
      pl_data  = 32'h0;
      if_le.req_valid = 1'b0; if_le.req_write = 1'b0; if_le.req_size = 2'b00;
      if_le.req_unsigned = 1'b0; if_le.req_addr = 32'h0; if_le.req_wdata = 32'h0;
      if_be.req_valid = 1'b0; if_be.req_write = 1'b0; if_be.req_size = 2'b00;
      if_be.req_unsigned = 1'b0; if_be.req_addr = 32'h0; if_be.req_wdata = 32'h0;
      test_reset();
      test_loads();
      test_sub_store();
      test_misaligned();
      test_reset_in_rmw();
      test_back_to_back();
      test_big_endian();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the single-cycle datapath's load/store control and the word-addressed data memory.
- Adds byte and halfword loads (sign- or zero-extended) and byte and halfword stores. Sub-word stores use a two-cycle read-modify-write, because the memory only writes full words.
- Detects misaligned accesses and blocks them from reaching memory.
- Presents a valid/ready request interface to the core and a registered response pulse.

Parameters:
- BIG_ENDIAN, 0, byte-lane order.
  - 0: byte at addr[1:0]=k occupies bits [8k+7:8k].
  - 1: byte at addr[1:0]=k occupies bits [8(3-k)+7:8(3-k)].

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core presents an access.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_write  in  1  1=store, 0=load.
- req_size  in  2  00=byte, 01=half, 10=word, 11=illegal.
- req_unsigned  in  1  loads only: 1=zero-extend, 0=sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte or low half is used for sub-word stores.
- resp_valid  out  1  one-cycle pulse when an accepted access completes.
- resp_rdata  out  32  extended load data; holds its value until the next load response.
- resp_exc  out  1  qualified by resp_valid; access was misaligned or illegal.
- mem_address  out  32  to data memory.
- mem_write  out  1  to data memory write enable.
- mem_write_data  out  32  to data memory.
- mem_read_data  in  32  from data memory; asynchronous read of mem_address[11:2].

Behaviour:
- Acceptance: accept = req_valid & req_ready. On accept, latch write, size, unsigned, addr and wdata.
- States:
  - IDLE
  - RMW: sub-word store write cycle
  - RESP: drives resp_valid
- Memory address:
  - In IDLE: mem_address = {req_addr[31:2],2'b00}.
  - In RMW: mem_address = {latched addr[31:2],2'b00}.
  - mem_write is combinational and is asserted only in the cases listed below.
- Misalignment:
  - Illegal when req_size=11, or half with addr[0]=1, or word with addr[1:0]≠0.
  - On an illegal accept: mem_write stays 0, go to RESP.
  - In RESP: resp_exc=1, resp_rdata unchanged.
- Load, accept cycle:
  - Select the lane from mem_read_data.
  - Sign- or zero-extend the byte or half; a word passes through unchanged.
  - Register the result into resp_rdata; go to RESP.
- Word store, accept cycle: mem_write=1, mem_write_data=req_wdata; go to RESP.
- Sub-word store:
  - Accept cycle: mem_write=0; register mem_read_data into merge_q; go to RMW.
  - RMW cycle: mem_write=1, mem_write_data = merge_q with the addressed byte or half replaced by latched wdata[7:0] or [15:0]. All other lanes are unchanged. Go to RESP.
- RESP:
  - resp_valid=1, resp_exc per the latched access, req_ready=0.
  - Next state is IDLE.
- Latency from accept to resp_valid:
  - Load: 1 cycle.
  - Word store: 1 cycle.
  - Misaligned access: 1 cycle.
  - Sub-word store: 2 cycles.
- Throughput: one access every 2 cycles (3 for sub-word stores). req_valid held while req_ready=0 is not accepted and must be held by the core.
- Reset:
  - State goes to IDLE.
  - resp_valid=0, resp_exc=0, resp_rdata=0, merge_q=0.
  - req_ready=1 the cycle after reset deasserts.
- Reset mid-operation:
  - Reset asserted in RMW: mem_write is forced to 0 that cycle, no partial write, no response.
  - Reset asserted in RESP: the response pulse is dropped.
- Signals while rst=1: mem_write=0, req_ready=0.
- Address wrap: only address bits [11:2] reach the memory. The full address is passed through and no range check is performed.

Test Plan:
1. Memory word at 0x10 = 0x8899AABB, BIG_ENDIAN=0:
   - lb at 0x13 -> resp_rdata=0xFFFFFF88 one cycle after accept.
   - lbu at 0x13 -> resp_rdata=0x00000088.
   - lh at 0x12 -> resp_rdata=0xFFFF8899.
2. sb at 0x11 with wdata=0x000000CC on word 0x11223344:
   - No write in the accept cycle.
   - mem_write=1 with 0x1122CC44 in the RMW cycle.
   - resp_valid 2 cycles after accept; a readback lw returns 0x1122CC44.
3. sh at 0x20 with wdata=0xDEADBEEF on word 0xFFFFFFFF -> memory holds 0xFFFFBEEF.
4. Misaligned requests, each checked separately:
   - lw at 0x22, sh at 0x21, req_size=11.
   - Required for each: mem_write never asserts, resp_valid=1 with resp_exc=1, resp_rdata keeps its previous value.
5. rst pulsed during the RMW cycle of an sb to 0x30 -> mem_write stays 0, word at 0x30 is unchanged, no resp_valid, req_ready=1 after rst is released.
6. Back-to-back: req_valid held high with an sw then an lw to 0x40:
   - Second request accepted only when req_ready=1.
   - lw returns the stored value.
   - Repeat with BIG_ENDIAN=1: lb at 0x40 of word 0xA1B2C3D4 -> 0xFFFFFFA1.
